// File: rtl/folded_threshold_unit.sv
// folded_threshold_unit
//   Sequential threshold/majority gate. An N-bit vector is accepted over a
//   valid/ready handshake and folded K bits per cycle into a running popcount.
//   The result is y_o = (popcount >= THRESH), along with the count and the
//   number of chunks consumed. With early exit enabled, accumulation stops on
//   the first chunk after which the outcome can no longer change.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake for x_i / early_exit_i
//   x_i             N-bit input vector
//   early_exit_i    1 = stop as soon as the result is decided
//   out_valid/ready output handshake for y_o / count_o / cycles_o
//   y_o             1 iff counted ones reach THRESH
//   count_o         ones counted over the consumed chunks
//   cycles_o        chunks consumed, 1..CHUNKS
module folded_threshold_unit #(
  parameter int N      = 49,
  parameter int K      = 8,
  parameter int THRESH = 25
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N-1:0]                      x_i,
  input  logic                              early_exit_i,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              y_o,
  output logic [$clog2(N+1)-1:0]            count_o,
  output logic [$clog2((N+K-1)/K+1)-1:0]    cycles_o
);
  localparam int CHUNKS = (N + K - 1) / K;
  localparam int CW     = $clog2(N + 1);
  localparam int IW     = $clog2(CHUNKS + 1);
  localparam int PW     = CHUNKS * K;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_x;       // zero-padded vector, shifted down K bits per chunk
  logic          r_ee;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_y;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_cycles;

  logic [CW-1:0] w_pop;
  logic [CW-1:0] w_cnt_next;
  logic          w_last;
  logic [31:0]   w_done_bits;
  logic [CW:0]   w_rem;
  logic [CW:0]   w_cnt_ext;
  logic [CW:0]   w_thr;
  logic          w_dec_hi;
  logic          w_dec_lo;

  // Popcount of the current low chunk; padding above N is already zero.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < K; i++) w_pop = w_pop + CW'(r_x[i]);
  end

  assign w_cnt_next = r_cnt + w_pop;
  assign w_last     = (r_idx == IW'(CHUNKS - 1));

  // Bits consumed after this edge, capped at N on the final (partial) chunk.
  assign w_done_bits = w_last ? 32'(N) : (32'(r_idx) + 32'd1) * 32'(K);
  assign w_rem       = (CW+1)'(32'(N) - w_done_bits);
  assign w_cnt_ext   = {1'b0, w_cnt_next};
  assign w_thr       = (CW+1)'(THRESH);
  // Decided high: threshold already met. Decided low: even all remaining
  // bits set could not reach it.
  assign w_dec_hi    = (w_cnt_ext >= w_thr);
  assign w_dec_lo    = ((w_cnt_ext + w_rem) < w_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_ee        <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= 1'b0;
      r_count     <= '0;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x        <= PW'(x_i);
            r_ee       <= early_exit_i;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          r_cnt <= w_cnt_next;
          r_idx <= r_idx + 1'b1;
          r_x   <= r_x >> K;
          if (w_last || (r_ee && (w_dec_hi || w_dec_lo))) begin
            r_y         <= w_dec_hi;
            r_count     <= w_cnt_next;
            r_cycles    <= r_idx + 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Output data is held after the handshake; only valid drops.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y_o       = r_y;
  assign count_o   = r_count;
  assign cycles_o  = r_cycles;

endmodule

// File: tb/tb_folded_threshold_unit.sv
module tb_folded_threshold_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] x_i;
  logic        early_exit_i;
  logic        out_valid;
  logic        out_ready;
  logic        y_o;
  logic [5:0]  count_o;
  logic [2:0]  cycles_o;

  int checks = 0;
  int failures = 0;

  localparam logic [48:0] ONES = {49{1'b1}};

  folded_threshold_unit #(.N(49), .K(8), .THRESH(25)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .early_exit_i(early_exit_i), .out_valid(out_valid),
    .out_ready(out_ready), .y_o(y_o), .count_o(count_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  // Present one vector, then count edges until out_valid (bounded).
  task automatic send(input logic [48:0] x, input logic ee, output int lat);
    @(negedge clk);
    in_valid = 1'b1; x_i = x; early_exit_i = ee;
    @(posedge clk); #1;
    in_valid = 1'b0; x_i = '0; early_exit_i = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({y_o, count_o, cycles_o} !== 10'd0) begin failures++; $display("FAIL reset_outputs got y=%b c=%0d cy=%0d exp 0/0/0", y_o, count_o, cycles_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_all_ones();
    int lat;
    send(ONES, 1'b0, lat);
    checks++; if (lat !== 7) begin failures++; $display("FAIL ones_latency got=%0d exp=7", lat); end
    checks++; if (y_o !== 1'b1) begin failures++; $display("FAIL ones_y got=%b exp=1", y_o); end
    checks++; if (count_o !== 6'd49) begin failures++; $display("FAIL ones_count got=%0d exp=49", count_o); end
    checks++; if (cycles_o !== 3'd7) begin failures++; $display("FAIL ones_cycles got=%0d exp=7", cycles_o); end
    consume();
  endtask

  task automatic test_boundary();
    int lat;
    send((49'd1 << 25) - 49'd1, 1'b0, lat);
    checks++; if (y_o !== 1'b1 || count_o !== 6'd25 || cycles_o !== 3'd7) begin failures++; $display("FAIL bound25 got y=%b c=%0d cy=%0d exp 1/25/7", y_o, count_o, cycles_o); end
    consume();
    send((49'd1 << 24) - 49'd1, 1'b0, lat);
    checks++; if (y_o !== 1'b0 || count_o !== 6'd24 || cycles_o !== 3'd7) begin failures++; $display("FAIL bound24 got y=%b c=%0d cy=%0d exp 0/24/7", y_o, count_o, cycles_o); end
    consume();
  endtask

  task automatic test_early_exit();
    int lat;
    send(ONES, 1'b1, lat);
    checks++; if (y_o !== 1'b1 || count_o !== 6'd32 || cycles_o !== 3'd4) begin failures++; $display("FAIL ee_ones got y=%b c=%0d cy=%0d exp 1/32/4", y_o, count_o, cycles_o); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ee_ones_latency got=%0d exp=4", lat); end
    consume();
    send('0, 1'b1, lat);
    checks++; if (y_o !== 1'b0 || count_o !== 6'd0 || cycles_o !== 3'd4) begin failures++; $display("FAIL ee_zero got y=%b c=%0d cy=%0d exp 0/0/4", y_o, count_o, cycles_o); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    // 8 low ones + bit 40 = 9 ones
    send(49'h100_0000_00FF, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; x_i = ONES;  // must be ignored in DONE
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_o !== 1'b0 || count_o !== 6'd9 || cycles_o !== 3'd7) begin
        failures++;
        $display("FAIL hold_%0d got v=%b r=%b y=%b c=%0d cy=%0d exp 1/0/0/9/7", i, out_valid, in_ready, y_o, count_o, cycles_o);
      end
    end
    in_valid = 1'b0; x_i = '0;
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL release got v=%b r=%b exp 0/1", out_valid, in_ready); end
    checks++; if (count_o !== 6'd9 || cycles_o !== 3'd7) begin failures++; $display("FAIL release_hold got c=%0d cy=%0d exp 9/7", count_o, cycles_o); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk); in_valid = 1'b1; x_i = ONES; early_exit_i = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || count_o !== 6'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset got v=%b c=%0d r=%b exp 0/0/1", out_valid, count_o, in_ready); end
    @(negedge clk); rst = 1'b0;
    send((49'd1 << 24) - 49'd1, 1'b0, lat);
    checks++; if (y_o !== 1'b0 || count_o !== 6'd24 || cycles_o !== 3'd7 || lat !== 7) begin failures++; $display("FAIL post_reset got y=%b c=%0d cy=%0d lat=%0d exp 0/24/7/7", y_o, count_o, cycles_o, lat); end
    consume();
  endtask

  task automatic test_random();
    int lat, w, pop;
    logic [48:0] x;
    logic ee;
    for (int n = 0; n < 4000; n++) begin
      ee = n[0];
      w = $urandom_range(30, 20);
      x = '0;
      while ($countones(x) < w) x[$urandom_range(48, 0)] = 1'b1;
      pop = $countones(x);
      send(x, ee, lat);
      checks++;
      if (lat >= 20) begin
        failures++; $display("FAIL rand_timeout n=%0d", n);
      end else if (y_o !== (pop >= 25)) begin
        failures++; $display("FAIL rand_y n=%0d ee=%b x=%h got=%b exp=%b", n, ee, x, y_o, pop >= 25);
      end else if (!ee && count_o !== 6'(pop)) begin
        failures++; $display("FAIL rand_count n=%0d x=%h got=%0d exp=%0d", n, x, count_o, pop);
      end
      consume();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_i = '0; early_exit_i = 1'b0; out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_boundary();
    test_early_exit();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
